// File: rtl/simple_datapath_if.sv
// Bus between the SimpleComputer controller side and simple_datapath: control word,
// program-store write port and the datapath's architectural outputs.
interface simple_datapath_if #(
   parameter int unsigned W  = 4,
   parameter int unsigned AW = 3,
   parameter int unsigned PW = 3
) ();
   logic [3:0]      ctrl;
   logic            prog_we;
   logic [PW-1:0]   prog_addr;
   logic [W+AW:0]   prog_data;
   logic            opcode;
   logic [W-1:0]    acc;
   logic [PW-1:0]   pc;
   logic            carry;
   logic            mem_wr;
   logic            err;

   modport master (
      output ctrl, prog_we, prog_addr, prog_data,
      input  opcode, acc, pc, carry, mem_wr, err
   );

   modport slave (
      input  ctrl, prog_we, prog_addr, prog_data,
      output opcode, acc, pc, carry, mem_wr, err
   );
endinterface

// File: rtl/simple_datapath.sv
// Execution datapath for the SimpleComputer controller: program store, accumulator,
// operand register and data memory. Define SIMPLE_DP_ADD_SAT_EN for a saturating ADD.
module simple_datapath #(
   parameter int unsigned W  = 4,
   parameter int unsigned AW = 3,
   parameter int unsigned PW = 3
) (
   input logic              clk,
   input logic              reset,
   simple_datapath_if.slave bus
);
   localparam int IW = 1 + W + AW;
   localparam int DD = 1 << AW;
   localparam int PD = 1 << PW;

   logic [IW-1:0] prog_q [PD];
   logic [W-1:0]  dmem_q [DD];

   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [PW-1:0] pc_q, pc_d;
   logic          carry_q, carry_d;
   logic          mem_wr_q, mem_wr_d;
   logic          err_q, err_d;
   logic          dmem_we;

   logic [IW-1:0] instr;
   logic          instr_add;
   logic [W-1:0]  instr_imm;
   logic [AW-1:0] instr_addr;

   logic [W:0]    sum;
   logic [W-1:0]  add_res;
   logic          add_carry;

   assign instr      = prog_q[pc_q];
   assign instr_add  = instr[IW-1];
   assign instr_imm  = instr[W+AW-1:AW];
   assign instr_addr = instr[AW-1:0];

   assign sum       = {1'b0, a_q} + {1'b0, b_q};
   assign add_carry = sum[W];
`ifdef SIMPLE_DP_ADD_SAT_EN
   assign add_res   = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
   assign add_res   = sum[W-1:0];
`endif

   // Anything other than exactly one control bit is illegal and only raises err.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      pc_d     = pc_q;
      carry_d  = carry_q;
      mem_wr_d = 1'b0;
      err_d    = err_q;
      dmem_we  = 1'b0;
      case (bus.ctrl)
         4'b1000: a_d = instr_imm;
         4'b0100: b_d = dmem_q[instr_addr];
         4'b0010: begin
            a_d     = add_res;
            carry_d = add_carry;
         end
         4'b0001: begin
            dmem_we  = 1'b1;
            mem_wr_d = 1'b1;
            pc_d     = pc_q + PW'(1);
         end
         default: err_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a_q      <= '0;
         b_q      <= '0;
         pc_q     <= '0;
         carry_q  <= 1'b0;
         mem_wr_q <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < DD; i++) dmem_q[i] <= '0;
         for (int i = 0; i < PD; i++) prog_q[i] <= '0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         pc_q     <= pc_d;
         carry_q  <= carry_d;
         mem_wr_q <= mem_wr_d;
         err_q    <= err_d;
         if (dmem_we) dmem_q[instr_addr] <= a_q;
         if (bus.prog_we) prog_q[bus.prog_addr] <= bus.prog_data;
      end
   end

   assign bus.opcode = instr_add;
   assign bus.acc    = a_q;
   assign bus.pc     = pc_q;
   assign bus.carry  = carry_q;
   assign bus.mem_wr = mem_wr_q;
   assign bus.err    = err_q;
endmodule

// File: tb/tb_simple_datapath.sv
// Bench for simple_datapath: directed vector table, opcode-flip sequence, then random
// stimulus against a behavioural model of the datapath rules.
module tb_simple_datapath;
   localparam int unsigned W  = 4;
   localparam int unsigned AW = 3;
   localparam int unsigned PW = 3;

`ifdef SIMPLE_DP_ADD_SAT_EN
   localparam int OVF_A = 15;
`else
   localparam int OVF_A = 1;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   simple_datapath_if #(.W(W), .AW(AW), .PW(PW)) bus ();

   simple_datapath #(.W(W), .AW(AW), .PW(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int rst_n, ctrl, we, pa, pd;
      int e_acc, e_pc, e_carry, e_mw, e_err, e_op;
      int m_addr, m_val;
   } vec_t;

   vec_t tbl[40];
   int   n_rows = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model state
   int m_prog[8];
   int m_dmem[8];
   int m_a, m_b, m_pc, m_carry, m_mw, m_err;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic row(input int rst_n, input int ctrl, input int we, input int pa, input int pd,
                      input int acc, input int pc, input int c, input int mw, input int err,
                      input int op, input int maddr, input int mval);
      tbl[n_rows] = '{rst_n, ctrl, we, pa, pd, acc, pc, c, mw, err, op, maddr, mval};
      n_rows++;
   endtask

   task automatic drive(input int rst_n, input int ctrl, input int we, input int pa, input int pd);
      reset         = rst_n[0];
      bus.ctrl      = 4'(ctrl);
      bus.prog_we   = we[0];
      bus.prog_addr = 3'(pa);
      bus.prog_data = 8'(pd);
   endtask

   task automatic model_step(input int rst_n, input int ctrl, input int we, input int pa,
                             input int pd);
      int ins, imm, addr, s;
      if (rst_n == 0) begin
         for (int i = 0; i < 8; i++) begin
            m_prog[i] = 0;
            m_dmem[i] = 0;
         end
         m_a = 0; m_b = 0; m_pc = 0; m_carry = 0; m_mw = 0; m_err = 0;
      end else begin
         ins  = m_prog[m_pc];
         imm  = (ins >> 3) & 15;
         addr = ins & 7;
         m_mw = 0;
         if (ctrl == 8) m_a = imm;
         else if (ctrl == 4) m_b = m_dmem[addr];
         else if (ctrl == 2) begin
            s       = m_a + m_b;
            m_carry = (s > 15) ? 1 : 0;
`ifdef SIMPLE_DP_ADD_SAT_EN
            m_a     = (s > 15) ? 15 : s;
`else
            m_a     = s % 16;
`endif
         end else if (ctrl == 1) begin
            m_dmem[addr] = m_a;
            m_mw         = 1;
            m_pc         = (m_pc + 1) % 8;
         end else m_err = 1;
         if (we != 0) m_prog[pa] = pd;
      end
   endtask

   initial begin
      int r, ctrl, rst_n, we, pa, pd;

      // rst ctrl we pa pd | acc pc c mw err op | mem addr/val (-1 = no check)
      row(0, 8, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0, -1, 0);
      row(1, 8, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0,  0, 0);
      row(1, 8, 1, 0, 8'h9A,  0, 0, 0, 0, 0, 1, -1, 0);
      row(1, 8, 1, 1, 8'hAA,  3, 0, 0, 0, 0, 1, -1, 0);
      row(1, 8, 1, 2, 8'hCA,  3, 0, 0, 0, 0, 1, -1, 0);
      row(1, 8, 0, 0, 8'h00,  3, 0, 0, 0, 0, 1, -1, 0);
      row(1, 4, 0, 0, 8'h00,  3, 0, 0, 0, 0, 1, -1, 0);
      row(1, 2, 0, 0, 8'h00,  3, 0, 0, 0, 0, 1, -1, 0);
      row(1, 1, 0, 0, 8'h00,  3, 1, 0, 1, 0, 1,  2, 3);
      row(1, 8, 0, 0, 8'h00,  5, 1, 0, 0, 0, 1, -1, 0);
      row(1, 4, 0, 0, 8'h00,  5, 1, 0, 0, 0, 1, -1, 0);
      row(1, 2, 0, 0, 8'h00,  8, 1, 0, 0, 0, 1, -1, 0);
      row(1, 1, 0, 0, 8'h00,  8, 2, 0, 1, 0, 1,  2, 8);
      row(1, 8, 0, 0, 8'h00,  9, 2, 0, 0, 0, 1, -1, 0);
      row(1, 4, 0, 0, 8'h00,  9, 2, 0, 0, 0, 1, -1, 0);
      row(1, 2, 0, 0, 8'h00,  OVF_A, 2, 1, 0, 0, 1, -1, 0);
      row(1, 1, 0, 0, 8'h00,  OVF_A, 3, 1, 1, 0, 0,  2, OVF_A);
      row(1, 8, 1, 3, 8'h34,  0, 3, 1, 0, 0, 0, -1, 0);
      row(1, 8, 0, 0, 8'h00,  6, 3, 1, 0, 0, 0, -1, 0);
      row(1, 4, 0, 0, 8'h00,  6, 3, 1, 0, 0, 0, -1, 0);
      row(1, 1, 0, 0, 8'h00,  6, 4, 1, 1, 0, 0,  4, 6);
      row(1, 1, 0, 0, 8'h00,  6, 5, 1, 1, 0, 0,  0, 6);
      row(1, 1, 0, 0, 8'h00,  6, 6, 1, 1, 0, 0, -1, 0);
      row(1, 1, 0, 0, 8'h00,  6, 7, 1, 1, 0, 0, -1, 0);
      row(1, 1, 0, 0, 8'h00,  6, 0, 1, 1, 0, 1, -1, 0);
      row(1, 6, 0, 0, 8'h00,  6, 0, 1, 0, 1, 1,  2, OVF_A);
      row(1, 0, 0, 0, 8'h00,  6, 0, 1, 0, 1, 1,  4, 6);
      row(1, 8, 0, 0, 8'h00,  3, 0, 1, 0, 1, 1, -1, 0);
      row(1, 8, 1, 0, 8'hBA,  3, 0, 1, 0, 1, 1, -1, 0);
      row(1, 8, 0, 0, 8'h00,  7, 0, 1, 0, 1, 1, -1, 0);
      row(0, 1, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0,  2, 0);
      row(1, 8, 0, 0, 8'h00,  0, 0, 0, 0, 0, 0,  0, 0);

      for (int i = 0; i < n_rows; i++) begin
         drive(tbl[i].rst_n, tbl[i].ctrl, tbl[i].we, tbl[i].pa, tbl[i].pd);
         @(posedge clk);
         #1;
         check($sformatf("row%0d_acc", i), int'(bus.acc), tbl[i].e_acc);
         check($sformatf("row%0d_pc", i), int'(bus.pc), tbl[i].e_pc);
         check($sformatf("row%0d_carry", i), int'(bus.carry), tbl[i].e_carry);
         check($sformatf("row%0d_mem_wr", i), int'(bus.mem_wr), tbl[i].e_mw);
         check($sformatf("row%0d_err", i), int'(bus.err), tbl[i].e_err);
         check($sformatf("row%0d_opcode", i), int'(bus.opcode), tbl[i].e_op);
         if (tbl[i].m_addr >= 0)
            check($sformatf("row%0d_dmem%0d", i, tbl[i].m_addr),
                  int'(dut.dmem_q[tbl[i].m_addr]), tbl[i].m_val);
      end
      for (int i = 0; i < 8; i++)
         check($sformatf("post_reset_dmem%0d", i), int'(dut.dmem_q[i]), 0);

      // Rewrite prog[pc] during MVD: opcode keeps the old bit until the next cycle.
      drive(1, 8, 1, 0, 8'h9A);
      @(posedge clk); #1;
      drive(1, 8, 0, 0, 8'h00);
      @(posedge clk); #1;
      check("flip_acc", int'(bus.acc), 3);
      drive(1, 4, 1, 0, 8'h1A);
      #1;
      check("flip_op_during_mvd", int'(bus.opcode), 1);
      @(posedge clk); #1;
      check("flip_op_after_mvd", int'(bus.opcode), 0);
      check("flip_b", int'(dut.b_q), 0);

      // Random phase, starting from a reset that both model and DUT see.
      for (int n = 0; n < 400; n++) begin
         rst_n = (n == 0 || $urandom_range(0, 39) == 0) ? 0 : 1;
         r     = $urandom_range(0, 9);
         ctrl  = (r < 8) ? (1 << (r % 4)) : $urandom_range(0, 15);
         we    = ($urandom_range(0, 4) == 0) ? 1 : 0;
         pa    = $urandom_range(0, 7);
         pd    = $urandom_range(0, 255);
         drive(rst_n, ctrl, we, pa, pd);
         model_step(rst_n, ctrl, we, pa, pd);
         @(posedge clk); #1;
         check($sformatf("rnd%0d_acc", n), int'(bus.acc), m_a);
         check($sformatf("rnd%0d_b", n), int'(dut.b_q), m_b);
         check($sformatf("rnd%0d_pc", n), int'(bus.pc), m_pc);
         check($sformatf("rnd%0d_carry", n), int'(bus.carry), m_carry);
         check($sformatf("rnd%0d_mem_wr", n), int'(bus.mem_wr), m_mw);
         check($sformatf("rnd%0d_err", n), int'(bus.err), m_err);
         check($sformatf("rnd%0d_opcode", n), int'(bus.opcode), (m_prog[m_pc] >> 7) & 1);
         for (int i = 0; i < 8; i++)
            check($sformatf("rnd%0d_dmem%0d", n, i), int'(dut.dmem_q[i]), m_dmem[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/simple_datapath.md
Name: simple_datapath

Overview:
- Execution-side counterpart to the SimpleComputer controller FSM.
- Consumes the controller's one-hot control word F (MOVI, MVD, ADD, STR) and performs the matching register, ALU and memory action.
- Returns the 1-bit opcode the controller branches on in its MVD state.
- Holds a small program store, an accumulator, an operand register and a data memory.

Parameters:
- W, 4, datapath/immediate width in bits.
- AW, 3, data memory address width; data memory depth = 2^AW.
- PW, 3, program counter width; program depth = 2^PW.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ctrl  in  4  controller F word: ctrl[3]=MOVI, ctrl[2]=MVD, ctrl[1]=ADD, ctrl[0]=STR.
- prog_we  in  1  program store write enable.
- prog_addr  in  PW  program store write address.
- prog_data  in  1+W+AW  instruction {add_bit, imm[W-1:0], addr[AW-1:0]}.
- opcode  out  1  add_bit of instr[pc]; combinational from pc and the program store.
- acc  out  W  accumulator A.
- pc  out  PW  program counter.
- carry  out  1  carry-out of the last ADD.
- mem_wr  out  1  one-cycle pulse, registered, on each STR.
- err  out  1  sticky illegal-control flag.

Behaviour:
- Reset (reset==0 at a clk edge):
  - A, B, pc, carry, mem_wr and err all go to 0.
  - All data memory words and all program words go to 0.
  - Reset wins over every other input in that cycle, including mid-instruction. In-flight ops are discarded and nothing is written.
- Current instruction: I = prog[pc]; I.imm and I.addr are its fields. opcode = I.add_bit at all times.
- ctrl is sampled each edge and must be exactly one-hot:
  - MOVI (1000): A <= I.imm.
  - MVD (0100): B <= dmem[I.addr]. The controller reads opcode in this cycle to pick ADD or STR next.
  - ADD (0010): {carry, A} <= A + B, computed at W+1 bits; A wraps mod 2^W.
  - STR (0001): dmem[I.addr] <= A; mem_wr <= 1 for the next cycle; pc <= pc+1, wrapping 2^PW-1 -> 0.
- Illegal ctrl (0000 or more than one bit set):
  - No architectural change to A, B, pc, carry or dmem; mem_wr <= 0.
  - err <= 1; err stays set until reset.
- carry changes only on ADD.
- mem_wr is 0 on every cycle that does not follow an STR.
- Program writes:
  - prog[prog_addr] <= prog_data on an edge with prog_we=1; allowed concurrently with any ctrl.
  - A write to prog[pc] is visible through I and opcode from the next cycle.
  - An op executing in the same cycle uses the old word.
- Data memory:
  - Read-before-write. MVD and STR never coincide (one-hot), so there is no read/write collision.
  - A read after an STR to the same address returns the stored value.
- Latency:
  - All register and memory effects are visible one cycle after the ctrl edge.
  - opcode follows pc with zero cycles.

Optional Feature:
- Macro: SIMPLE_DP_ADD_SAT_EN.
- Defined: ADD saturates. If the (W+1)-bit sum exceeds 2^W-1, then A <= 2^W-1 and carry <= 1; otherwise same as the base behaviour.
- Undefined: ADD wraps mod 2^W as specified above; carry still reports overflow.

Test Plan:
- Reset, then idle with ctrl=1000 and prog all zero -> A=0, pc=0, opcode=0, err=0, dmem[0..7]=0.
- Load prog0={1,3,2}; run MOVI,MVD,ADD,STR -> A=3, B=0, opcode=1 during MVD, dmem[2]=3, mem_wr high for 1 cycle, pc=1.
- Load prog1={1,5,2}, prog2={1,9,2}; run two more full cycles:
  - after prog1: dmem[2]=8, carry=0.
  - after prog2: A=1, carry=1, dmem[2]=1. With SIMPLE_DP_ADD_SAT_EN: A=15, dmem[2]=15.
- prog={0,6,4}; run MOVI,MVD,STR (ADD skipped because opcode=0) -> dmem[4]=6, carry unchanged. Run 8 STR sequences from pc=0 -> pc wraps from 7 back to 0.
- ctrl=0110, then ctrl=0000 -> err=1, A/B/pc/dmem unchanged. err stays 1 through later legal ops; cleared only by reset=0.
- Assert reset=0 in the same cycle as an STR with A=7 -> dmem unchanged (0), pc=0, mem_wr=0 on the next cycle.
- prog_we to prog[pc] in the MVD cycle, flipping add_bit 1->0 -> opcode=1 in that cycle, 0 in the following cycle.
